vga_capture: RTL and testbench

//  Receive side of the 1-bit-per-colour VGA link. Samples hsync/vsync/red/green/blue
//  on the pixel tick, rebuilds pixel position and active flag, measures line/frame

---
 rtl/vga_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_vga_capture.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: receive side of the 1-bit-per-colour VGA link.
// Samples syncs and colours on ptick and rebuilds the pixel position and active flag.
// Measures line and frame totals and reports timing lock.
// Outputs update one clk after the sampling ptick.
// Ports:
//   clk, reset (async, active-high), ptick (pixel enable)
//   hsync, vsync (polarity SYNC_POL), red, green, blue
//   xpos, ypos, active, pixel_rgb, frame_tick, locked, h_total, v_total
// Optional: define VGA_CAPTURE_CRC_EN to add frame_crc[15:0].
//   frame_crc is a CRC-16-CCITT of the active pixels, latched on the vsync leading edge.
module vga_capture #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ptick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        red,
  input  logic        green,
  input  logic        blue,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic        active,
  output logic [2:0]  pixel_rgb,
  output logic        frame_tick,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [10:0] v_total
`ifdef VGA_CAPTURE_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam int unsigned CW       = 11;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] H_LO   = CW'(H_BACK);
  localparam logic [CW-1:0] H_HI   = CW'(H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] V_LO   = CW'(V_BACK);
  localparam logic [CW-1:0] V_HI   = CW'(V_BACK + V_ACTIVE);
  localparam logic [3:0]    CNT_LAST = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED} lock_state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // Sample stage; sync levels are stored as "asserted" flags.
  logic          smp_vld, smp_hs, smp_vs;
  logic [2:0]    smp_rgb;

  always_ff @(posedge clk or posedge reset) begin : sample_stage
    if (reset) begin
      smp_vld <= 1'b0;
      smp_hs  <= 1'b0;
      smp_vs  <= 1'b0;
      smp_rgb <= '0;
    end else begin
      smp_vld <= ptick;
      if (ptick) begin
        smp_hs  <= (hsync == SYNC_POL);
        smp_vs  <= (vsync == SYNC_POL);
        smp_rgb <= {red, green, blue};
      end
    end
  end

  logic          hs_prev, vs_prev, h_seen, v_seen;
  logic [CW-1:0] hcnt, vcnt, htick, vline;
  lock_state_t   state;
  logic [CW-1:0] ref_h, ref_v;
  logic [3:0]    match_cnt;

  logic          hs_lead, hs_trail, vs_lead, vs_trail;
  logic          h_seen_nxt, v_seen_nxt, act_h, act_v, act_pix;
  logic [CW-1:0] hcnt_nxt, vcnt_nxt, vline_inc, htot_nxt, vtot_nxt;
  logic          h_bad, tot_sat, tot_good;
  lock_state_t   st_h;

  // Edge detection and the next counter values for the pending sample.
  always_comb begin : decode
    hs_lead    = smp_hs & ~hs_prev;
    hs_trail   = ~smp_hs & hs_prev;
    vs_lead    = smp_vs & ~vs_prev;
    vs_trail   = ~smp_vs & vs_prev;
    h_seen_nxt = h_seen | hs_trail;
    v_seen_nxt = v_seen | vs_trail;
    hcnt_nxt   = hs_trail ? '0 : sat_inc(hcnt);
    // hsync leading edge is counted before a coincident vsync clear.
    vcnt_nxt   = vs_trail ? '0 : (hs_lead ? sat_inc(vcnt) : vcnt);
    vline_inc  = hs_lead ? sat_inc(vline) : vline;
    htot_nxt   = hs_lead ? htick : h_total;
    vtot_nxt   = vs_lead ? vline_inc : v_total;
    act_h      = h_seen_nxt && (hcnt_nxt >= H_LO) && (hcnt_nxt < H_HI);
    act_v      = v_seen_nxt && (vcnt_nxt >= V_LO) && (vcnt_nxt < V_HI);
    act_pix    = act_h & act_v;
    // A new line length while locked drops lock before any vsync handling.
    h_bad      = (htick != ref_h) || (htick == CNT_MAX);
    st_h       = (state == S_LOCKED && hs_lead && h_bad) ? S_SEARCH : state;
    tot_sat    = (htot_nxt == CNT_MAX) || (vtot_nxt == CNT_MAX);
    tot_good   = (htot_nxt == ref_h) && (vtot_nxt == ref_v) && !tot_sat;
  end

  // Position, active area and line/frame measurement.
  always_ff @(posedge clk or posedge reset) begin : timing
    if (reset) begin
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      h_seen     <= 1'b0;
      v_seen     <= 1'b0;
      hcnt       <= '0;
      vcnt       <= '0;
      htick      <= '0;
      vline      <= '0;
      xpos       <= '0;
      ypos       <= '0;
      active     <= 1'b0;
      pixel_rgb  <= '0;
      frame_tick <= 1'b0;
      h_total    <= '0;
      v_total    <= '0;
    end else begin
      frame_tick <= smp_vld & vs_lead;
      if (smp_vld) begin
        hs_prev   <= smp_hs;
        vs_prev   <= smp_vs;
        h_seen    <= h_seen_nxt;
        v_seen    <= v_seen_nxt;
        hcnt      <= hcnt_nxt;
        vcnt      <= vcnt_nxt;
        htick     <= hs_lead ? CW'(1) : sat_inc(htick);
        vline     <= vs_lead ? '0 : vline_inc;
        h_total   <= htot_nxt;
        v_total   <= vtot_nxt;
        active    <= act_pix;
        pixel_rgb <= act_pix ? smp_rgb : 3'b000;
        if (act_h) xpos <= 10'(hcnt_nxt - H_LO);
        if (act_v) ypos <= 10'(vcnt_nxt - V_LO);
      end
    end
  end

  // Lock tracker, evaluated at each vsync leading edge.
  always_ff @(posedge clk or posedge reset) begin : lock_fsm
    if (reset) begin
      state     <= S_SEARCH;
      ref_h     <= '0;
      ref_v     <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else if (smp_vld) begin
      state  <= st_h;
      locked <= (st_h == S_LOCKED);
      if (vs_lead) begin
        unique case (st_h)
          S_SEARCH: begin
            ref_h     <= htot_nxt;
            ref_v     <= vtot_nxt;
            match_cnt <= 4'd1;
            if (LOCK_FRAMES == 1 && !tot_sat) begin
              state  <= S_LOCKED;
              locked <= 1'b1;
            end else begin
              state <= S_TRACK;
            end
          end
          S_TRACK: begin
            if (tot_good) begin
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt == CNT_LAST) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              ref_h     <= htot_nxt;
              ref_v     <= vtot_nxt;
              match_cnt <= 4'd1;
            end
          end
          S_LOCKED: begin
            if (!tot_good) begin
              state  <= S_SEARCH;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= S_SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  // CRC-16-CCITT over 3 bits per active pixel, red first.
  function automatic logic [15:0] crc_step3(input logic [15:0] c, input logic [2:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 2; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc_acc, crc_upd;

  always_comb begin : crc_next
    crc_upd = act_pix ? crc_step3(crc_acc, smp_rgb) : crc_acc;
  end

  always_ff @(posedge clk or posedge reset) begin : crc_reg
    if (reset) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= '0;
    end else if (smp_vld) begin
      if (vs_lead) begin
        frame_crc <= crc_upd;
        crc_acc   <= 16'hFFFF;
      end else begin
        crc_acc   <= crc_upd;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized generator stub driving vga_capture.
// A reference model predicts every sampled output; a monitor pops the prediction and compares it.
// Uses a reduced 28x13 timing (16x6 active) so the run stays short.
// Set VGA_CAPTURE_CRC_EN to also check frame_crc.
module tb_vga_capture;

  localparam int unsigned HA = 16, HB = 4, VA = 6, VB = 3, LF = 2;
  localparam bit          POL = 1'b0;
  localparam int          HLEN = 28, VLEN = 13, SAT = 2047;

  logic        clk, reset, ptick, hsync, vsync, red, green, blue;
  logic [9:0]  xpos, ypos;
  logic        active, frame_tick, locked;
  logic [2:0]  pixel_rgb;
  logic [10:0] h_total, v_total;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
`endif

  vga_capture #(.H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB),
                .SYNC_POL(POL), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset), .ptick(ptick), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .xpos(xpos), .ypos(ypos),
    .active(active), .pixel_rgb(pixel_rgb), .frame_tick(frame_tick),
    .locked(locked), .h_total(h_total), .v_total(v_total)
`ifdef VGA_CAPTURE_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x, y;
    logic        act;
    logic [2:0]  rgb;
    logic        ft, lk;
    logic [10:0] ht, vt;
    logic [15:0] crc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;

  // Reference model state: positions are derived from sample indices of sync edges.
  int m_idx, m_htrail, m_hlead, m_lines, m_leads, m_ht, m_vt, m_lastx, m_lasty;
  bit m_hs_prev, m_vs_prev, m_hseen, m_vseen;
  bit m_lk, m_have;
  int m_rh, m_rv, m_cnt;
  logic [15:0] m_acc, m_fcrc;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_htrail = 0; m_hlead = 1; m_lines = 0; m_leads = 0;
    m_ht = 0; m_vt = 0; m_lastx = 0; m_lasty = 0;
    m_hs_prev = 0; m_vs_prev = 0; m_hseen = 0; m_vseen = 0;
    m_lk = 0; m_have = 0; m_rh = 0; m_rv = 0; m_cnt = 0;
    m_acc = 16'hFFFF; m_fcrc = 16'h0;
  endtask

  task automatic model_step(input bit hs_a, input bit vs_a, input logic [2:0] c);
    bit hl, ht, vl, vt, ah, av, good;
    int hc;
    exp_t e;
    m_idx++;
    hl = hs_a && !m_hs_prev;  ht = !hs_a && m_hs_prev;
    vl = vs_a && !m_vs_prev;  vt = !vs_a && m_vs_prev;
    m_hs_prev = hs_a; m_vs_prev = vs_a;
    if (ht) begin m_htrail = m_idx; m_hseen = 1; end
    hc = sat(m_idx - m_htrail);
    if (hl) begin
      m_lines = sat(m_lines + 1);
      m_leads = sat(m_leads + 1);
      m_ht    = sat(m_idx - m_hlead);
      m_hlead = m_idx;
      if (m_lk && (m_ht != m_rh || m_ht == SAT)) begin m_lk = 0; m_have = 0; end
    end
    if (vt) begin m_lines = 0; m_vseen = 1; end
    ah = m_hseen && hc >= HB && hc < HB + HA;
    av = m_vseen && m_lines >= VB && m_lines < VB + VA;
    if (ah) m_lastx = hc - HB;
    if (av) m_lasty = m_lines - VB;
    if (ah && av)
      for (int i = 2; i >= 0; i--)
        m_acc = (m_acc[15] ^ c[i]) ? ({m_acc[14:0], 1'b0} ^ 16'h1021) : {m_acc[14:0], 1'b0};
    if (vl) begin
      m_vt = m_leads; m_leads = 0;
      m_fcrc = m_acc; m_acc = 16'hFFFF;
      good = (m_ht == m_rh) && (m_vt == m_rv) && m_ht != SAT && m_vt != SAT;
      if (m_lk) begin
        if (!good) begin m_lk = 0; m_have = 0; end
      end else if (!m_have) begin
        m_rh = m_ht; m_rv = m_vt; m_cnt = 1; m_have = 1;
      end else if (good) begin
        m_cnt++;
        if (m_cnt >= LF) m_lk = 1;
      end else begin
        m_rh = m_ht; m_rv = m_vt; m_cnt = 1;
      end
    end
    e.x = 10'(m_lastx); e.y = 10'(m_lasty); e.act = ah && av;
    e.rgb = (ah && av) ? c : 3'b000; e.ft = vl; e.lk = m_lk;
    e.ht = 11'(m_ht); e.vt = 11'(m_vt); e.crc = m_fcrc;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: one prediction per ptick, compared after the output update edge.
  initial begin : monitor
    exp_t e;
    bit ok;
    forever begin
      @(posedge clk);
      if (ptick) begin
        @(posedge clk); #1;
        n_chk++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_empty: got output update, want queued prediction");
        end else begin
          e = sb.pop_front();
          ok = (xpos == e.x) && (ypos == e.y) && (active == e.act) && (pixel_rgb == e.rgb) &&
               (frame_tick == e.ft) && (locked == e.lk) && (h_total == e.ht) && (v_total == e.vt);
`ifdef VGA_CAPTURE_CRC_EN
          ok = ok && (frame_crc == e.crc);
`endif
          if (!ok) begin
            n_err++;
            $display("FAIL sample t=%0t: got x=%0d y=%0d act=%0d rgb=%0d ft=%0d lk=%0d ht=%0d vt=%0d, want x=%0d y=%0d act=%0d rgb=%0d ft=%0d lk=%0d ht=%0d vt=%0d",
                     $time, xpos, ypos, active, pixel_rgb, frame_tick, locked, h_total, v_total,
                     e.x, e.y, e.act, e.rgb, e.ft, e.lk, e.ht, e.vt);
          end
        end
      end
    end
  end

  task automatic send(input bit hs_a, input bit vs_a, input logic [2:0] c);
    @(negedge clk);
    hsync = hs_a ? POL : !POL;
    vsync = vs_a ? POL : !POL;
    {red, green, blue} = c;
    model_step(hs_a, vs_a, c);
    ptick = 1'b1;
    @(negedge clk);
    ptick = 1'b0;
    if ($urandom_range(0, 1) == 1) @(negedge clk);
  endtask

  task automatic settle();
    @(posedge clk); #3;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_xpos"}, xpos, 0);           chk({tag, "_ypos"}, ypos, 0);
    chk({tag, "_active"}, active, 0);       chk({tag, "_rgb"}, pixel_rgb, 0);
    chk({tag, "_ftick"}, frame_tick, 0);    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_htotal"}, h_total, 0);      chk({tag, "_vtotal"}, v_total, 0);
  endtask

  task automatic mid_reset();
    settle();
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    reset = 1'b0;
    model_reset();
  endtask

  // Pattern: 0 random everywhere, 1 white corners, 2 black, 3 one red pixel.
  function automatic logic [2:0] pix(input int pat, input int x, input int y);
    case (pat)
      0: return 3'($urandom_range(0, 7));
      1: return ((x == 0 && y == 0) || (x == HA - 1 && y == VA - 1)) ? 3'b111 : 3'b000;
      3: return (x == 5 && y == 2) ? 3'b100 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  // Line: active 0..15, front porch, hsync 4 ticks, back porch 4; 'e' extra front-porch ticks.
  task automatic gen_line(input int y, input int e, input int pat, input int rst_x);
    for (int x = 0; x < HLEN + e; x++) begin
      if (x == rst_x) mid_reset();
      send((x >= 20 + e) && (x < 24 + e), (y >= 8) && (y < 10), pix(pat, x, y));
    end
  endtask

  task automatic gen_frame(input int long_line, input int pat);
    for (int y = 0; y < VLEN; y++) gen_line(y, (y == long_line) ? 1 : 0, pat, -1);
  endtask

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_a, crc_b, crc_c;
`endif

  initial begin : stimulus
    reset = 1'b1; ptick = 1'b0; hsync = !POL; vsync = !POL;
    red = 1'b0; green = 1'b0; blue = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    repeat (4) gen_frame(-1, 0);
    settle();
    chk("lock_acquire", locked, 1);
    chk("h_total_nominal", h_total, HLEN);
    chk("v_total_nominal", v_total, VLEN);

    gen_frame(-1, 1);

    gen_frame(2, 0);
    settle();
    chk("lock_lost_long_line", locked, 0);
    repeat (2) gen_frame(-1, 0);
    settle();
    chk("relock_after_long_line", locked, 1);

    repeat (3000) send(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    gen_line(0, 0, 0, -1);
    settle();
    chk("h_total_saturated", h_total, SAT);
    chk("locked_after_missing_hsync", locked, 0);
    chk("active_after_missing_hsync", active, 0);
    repeat (3) gen_frame(-1, 0);
    settle();
    chk("relock_after_missing_hsync", locked, 1);

    for (int y = 0; y < 3; y++) gen_line(y, 0, 0, -1);
    gen_line(3, 0, 0, 8);
    gen_line(4, 0, 0, -1);
    settle();
    chk("xpos_after_reset_line", xpos, HA - 1);
    chk("active_before_vsync_resync", active, 0);
    for (int y = 5; y < VLEN; y++) gen_line(y, 0, 0, -1);
    repeat (2) gen_frame(-1, 0);
    settle();
    chk("relock_after_reset", locked, 1);

`ifdef VGA_CAPTURE_CRC_EN
    gen_frame(-1, 2); settle(); crc_a = frame_crc;
    gen_frame(-1, 3); settle(); crc_b = frame_crc;
    gen_frame(-1, 2); settle(); crc_c = frame_crc;
    n_chk++;
    if (crc_a == crc_b) begin
      n_err++;
      $display("FAIL crc_black_vs_red: got equal %h, want differing", crc_a);
    end
    chk("crc_repeatable", crc_c, crc_a);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
